// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 1;
    localparam int NDIG      = DEF_WIDTH / DEF_DIGIT;

    // Digit-counter width: clog2(width/digit), never less than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int w;
        int n;
        n = width / digit;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done operation bus between a controller and the serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    // start is sampled only when the adder is idle or done; busy/done/S/Cout are driven by the adder.
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (output start, A, B, Cin, input busy, done, S, Cout);
    modport slave  (input start, A, B, Cin, output busy, done, S, Cout);
endinterface

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    input  logic             Ci,
    output logic [DIGIT-1:0] S,
    output logic             Co
);
    logic c;

    always_comb begin
        c = Ci;
        S = '0;
        for (int i = 0; i < DIGIT; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Co = c;
    end
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: S = A + B + Cin, DIGIT bits per clock, LSB digit first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_if.slave      bus,
    output sa_state_e          state_dbg
);
    localparam int NDIGITS = WIDTH / DIGIT;
    localparam int CNT_W   = cnt_width(WIDTH, DIGIT);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "serial_adder: WIDTH must be in 2..64");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $fatal(1, "serial_adder: DIGIT must divide WIDTH");
    end

    sa_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic [WIDTH-1:0] s_next;

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .A  (a_sh_q[DIGIT-1:0]),
        .B  (b_sh_q[DIGIT-1:0]),
        .Ci (carry_q),
        .S  (dig_s),
        .Co (dig_co)
    );

    // New digit enters at the top; after NDIGITS shifts the first digit sits at bit 0.
    assign s_next = WIDTH'({dig_s, s_sh_q} >> DIGIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        s_d     = s_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.B;
                    carry_d = bus.Cin;
                    cnt_d   = '0;
                    s_sh_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_sh_d  = s_next;
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                carry_d = dig_co;
                cnt_d   = cnt_q + CNT_W'(1);
                // Visible result is only updated when the last digit lands.
                if (cnt_q == CNT_W'(NDIGITS - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    s_d     = s_next;
                    cout_d  = dig_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.S     = s_q;
    assign bus.Cout  = cout_q;
    assign state_dbg = state_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Multi-cycle parametrised adder that computes S = A + B + Cin. It processes DIGIT bits per clock, from LSB to MSB, and carries between cycles through a registered carry flip-flop. It is the sequential successor to the team's 1-bit full adder and is aimed at area-constrained datapaths in the combinational/sequential design set. It uses a start/busy/done handshake so that a controller can issue operations back-to-back.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..64.
DIGIT, 1, bits added per clock; must divide WIDTH exactly (elaboration-time check; illegal value = fatal).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  launch request; sampled only in IDLE or DONE.
A  input  WIDTH  operand A; captured on an accepted start.
B  input  WIDTH  operand B; captured on an accepted start.
Cin  input  1  carry-in; captured on an accepted start.
busy  output  1  high while an operation is in progress (RUN).
done  output  1  one-cycle pulse when S/Cout become valid.
S  output  WIDTH  sum; held stable from done until the next accepted start.
Cout  output  1  carry-out of the MSB; held with S.

Behaviour:
- Reset (async assert, sync deassert expected upstream): state=IDLE, busy=0, done=0, S=0, Cout=0, digit counter=0, carry register=0, operand shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> capture A, B into shift registers; carry reg=Cin; counter=0; go to RUN. start=0 -> stay.
- RUN: busy=1. Each cycle:
  - add the low DIGIT bits of A_sh and B_sh with the carry reg (ripple of DIGIT full-adder cells);
  - shift the result digit into the top of S_sh (right shift, so the LSB digit ends at the bottom after WIDTH/DIGIT cycles);
  - shift A_sh and B_sh right by DIGIT;
  - carry reg = digit carry-out;
  - counter++.
  - When counter == WIDTH/DIGIT-1, that cycle's digit is the last one: next state is DONE, S is loaded from the completed shift register, and Cout = final carry.
- Latency: start accepted at edge k -> done=1 in the cycle after edge k+WIDTH/DIGIT. For WIDTH=8, DIGIT=1: done is high 8 cycles after the accepting edge. For DIGIT=WIDTH: 1 cycle.
- DONE: done=1 for exactly one cycle; busy=0.
  - start=1 in DONE -> accepted (back-to-back); go directly to RUN with new operands. S/Cout keep their old values until the new done.
  - start=0 -> IDLE.
- start while busy: ignored, with no effect on the operation in flight.
- Operands and Cin are sampled only on the accepting edge; later changes are irrelevant.
- Overflow: result is modulo 2^WIDTH. Cout carries bit WIDTH; there are no other flags.
- rst asserted mid-RUN: immediate abort to the reset values; no done is produced.
- S/Cout change only on the cycle done asserts (or on reset), never during RUN.

Decomposition:
- Shared package serial_adder_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), a function computing counter width clog2(WIDTH/DIGIT) with a minimum of 1, and a localparam NDIG = WIDTH/DIGIT.
- Sub-module adder_digit: purely combinational DIGIT-bit ripple adder (parameter DIGIT; ports A, B, Ci, S, Co) built from full-adder cells. This gives a single place to reuse the existing full-adder equations.

Test Plan:
- WIDTH=8, DIGIT=1: A=8'h00, B=8'h00, Cin=0 -> done 8 cycles after start; S=8'h00, Cout=0. Then all 8 single-bit full-adder truth-table combinations are applied on bit 0 with A/B upper bits zero, checking S[0] and S[1] as the carry.
- WIDTH=8, DIGIT=1: A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1. A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF, Cout=1.
- WIDTH=16, DIGIT=4: A=16'h1234, B=16'h0FCD, Cin=1 -> done 4 cycles after start; S=16'h2202, Cout=0. Also check busy=1 for exactly 4 cycles.
- Back-to-back: start held high at DONE with new A=8'h7F, B=8'h01 -> re-enters RUN with no IDLE cycle. The previous S stays stable until the next done, when S=8'h80, Cout=0.
- start pulsed mid-RUN with different operands -> ignored; result matches the original operands and there is only one done pulse.
- rst asserted at cycle 3 of RUN -> busy=0, done=0, S=0, Cout=0 immediately, with no done afterwards. A fresh start then completes correctly. A randomized 1000-vector compare against A+B+Cin is run for DIGIT ∈ {1,2,8}.
